// File: rtl/data_memory.sv
// data_memory: word-organised data memory for the MIPS memory stage.
// Synchronous full-word stores, combinational gated loads, synchronous clear.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] wr_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] rd_data
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BYTE_OFFS = 2;
  localparam int unsigned IDX_HI    = ADDR_BITS + BYTE_OFFS - 1;

  logic [DATA_W-1:0]    mem [DEPTH_WORDS];
  logic [ADDR_BITS-1:0] word_idx;

  // Byte offset and high bits are dropped: unaligned accesses hit the
  // containing word and the address space wraps modulo the array size.
  assign word_idx = addr_in[IDX_HI:BYTE_OFFS];

  // Dropped address bits folded into one signal so they read as deliberate.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_in[DATA_W-1:IDX_HI+1], addr_in[BYTE_OFFS-1:0]};

  // Store port; reset clears every word and overrides a concurrent store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (MemWrite) begin
      mem[word_idx] <= wr_data;
    end
  end

  // Load port; zero unless a load is requested outside reset, no store bypass.
  always_comb begin
    rd_data = '0;
    if (MemRead && !rst) begin
      rd_data = mem[word_idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] addr_in;
  logic [31:0] wr_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] rd_data;

  int n_tests;
  int n_fail;

  data_memory #(
    .DEPTH_WORDS(256),
    .ADDR_BITS  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr_in (addr_in),
    .wr_data (wr_data),
    .MemWrite(MemWrite),
    .MemRead (MemRead),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then step clear of it before touching inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational read path, then compare rd_data against expectation.
  task automatic check(input string tag, input logic [31:0] exp);
    #1;
    n_tests++;
    assert (rd_data === exp)
    else begin
      n_fail++;
      $error("FAIL %s: rd_data=%08h expected %08h", tag, rd_data, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemRead  = 1'b0;
    MemWrite = 1'b1;
    addr_in  = a;
    wr_data  = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    addr_in  = a;
    check(tag, exp);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    addr_in  = '0;
    wr_data  = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;

    // Reset for two edges; read stays forced to zero during reset
    tick();
    tick();
    MemRead = 1'b1;
    check("rst_forces_zero", 32'h0);
    rst = 1'b0;
    load("post_rst_clear_0x10", 32'h10, 32'h0);

    // 1: single store then same-cycle load
    store(32'h0, 32'h000000AA);
    load("t1_read_0x0", 32'h0, 32'h000000AA);

    // 2: multiple stores
    store(32'h4, 32'h0000BEEF);
    store(32'h8, 32'h00000BAD);
    load("t2_read_0x4", 32'h4, 32'h0000BEEF);
    load("t2_read_0x8", 32'h8, 32'h00000BAD);
    load("t2_read_0x0", 32'h0, 32'h000000AA);

    // 3: read gating, no clock edge between the two checks
    MemRead = 1'b0;
    addr_in = 32'h4;
    check("t3_gated_off", 32'h0);
    MemRead = 1'b1;
    check("t3_gated_on", 32'h0000BEEF);

    // 4: unaligned offset and address wrap
    load("t4_unaligned_0x6", 32'h6, 32'h0000BEEF);
    store(32'h400, 32'h12345678);
    load("t4_wrap_0x0", 32'h0, 32'h12345678);
    store(32'h3FC, 32'hDEAD0001);
    load("t4_top_word_wrap", 32'hFFFFFFFF, 32'hDEAD0001);

    // No store when MemWrite is low
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    addr_in  = 32'h10;
    wr_data  = 32'h55555555;
    tick();
    load("no_write_0x10", 32'h10, 32'h0);

    // 5: simultaneous load and store, same address, no bypass
    MemRead  = 1'b1;
    MemWrite = 1'b1;
    addr_in  = 32'h8;
    wr_data  = 32'h0000CAFE;
    check("t5_before_edge", 32'h00000BAD);
    tick();
    MemWrite = 1'b0;
    check("t5_after_edge", 32'h0000CAFE);

    // 6: reset has priority over a concurrent store and clears everything
    rst      = 1'b1;
    MemWrite = 1'b1;
    MemRead  = 1'b1;
    addr_in  = 32'hC;
    wr_data  = 32'h0000FFFF;
    check("t6_rd_zero_in_rst", 32'h0);
    tick();
    rst      = 1'b0;
    MemWrite = 1'b0;
    load("t6_read_0xC", 32'hC, 32'h0);
    load("t6_read_0x4", 32'h4, 32'h0);
    load("t6_read_0x8", 32'h8, 32'h0);
    load("t6_read_0x0", 32'h0, 32'h0);
    load("t6_read_0x3FC", 32'h3FC, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
